ctrl_flow_unit: RTL and testbench

Parametrised successor to the execute-stage control-flow logic.
- Resolves conditional branches against a P/N/Z-style flag register.
- Keeps a configurable-depth return-address stack (RAS).
- Supports nested interrupts with per-level saved PC and saved flags.
- Sits in the execute stage between the ALU (target address, flag results) and fetch (branch_addr/branch_taken).

---
 rtl/ctrl_flow_pkg.sv | 14 +
 rtl/ctrl_flow_unit_lifo_stack.sv | 62 ++++++
 rtl/ctrl_flow_unit.sv | 104 ++++++++++
 tb/tb_ctrl_flow_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_flow_pkg.sv
// Shared constants for the execute-stage control-flow unit.
package ctrl_flow_pkg;

  localparam int FLAG_P = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam int ERR_OVF = 0;
  localparam int ERR_UNF = 1;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_FLAG_W = 3;

endpackage

// File: rtl/ctrl_flow_unit_lifo_stack.sv
// Circular-buffer LIFO with a saturating occupancy count; OVERWRITE=1 drops the oldest entry when full.
module lifo_stack #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, top_ptr;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CNT_MAX);
  assign overflow  = push & full;
  assign underflow = pop & empty;
  assign top_ptr   = (wr_ptr_q == '0) ? PTR_MAX : wr_ptr_q - 1'b1;
  assign top       = mem_q[top_ptr];

  // wr_ptr is the next free slot; when full it also marks the oldest entry
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push && (!full || OVERWRITE)) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      wr_ptr_d = top_ptr;
      cnt_d    = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ctrl_flow_unit.sv
// Execute-stage control flow: flag-tested branches, return-address stack, nested interrupts.
module ctrl_flow_unit
  import ctrl_flow_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int FLAG_W    = DEF_FLAG_W,
  parameter int RAS_DEPTH = 8,
  parameter int INT_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [ADDR_W-1:0]              pc,
  input  logic [ADDR_W-1:0]              target,
  input  logic                           br,
  input  logic [FLAG_W-1:0]              cond_mask,
  input  logic                           save_addr,
  input  logic                           ret,
  input  logic                           flag_wr,
  input  logic [FLAG_W-1:0]              flag_in,
  input  logic                           int_req,
  input  logic [ADDR_W-1:0]              int_vector,
  input  logic                           err_clr,
  output logic                           branch_taken,
  output logic [ADDR_W-1:0]              branch_addr,
  output logic                           int_ack,
  output logic [$clog2(INT_DEPTH+1)-1:0] int_level,
  output logic [FLAG_W-1:0]              flags,
  output logic [1:0]                     ras_err
);
  localparam int LVL_W  = $clog2(INT_DEPTH + 1);
  localparam int ISTK_W = ADDR_W + FLAG_W;

  logic [FLAG_W-1:0] flags_q, flags_d;
  logic [LVL_W-1:0]  int_level_q, int_level_d;
  logic [1:0]        ras_err_q, ras_err_d;

  logic              int_acc, ret_int, ret_sub, br_tkn, ras_push;
  logic [ADDR_W-1:0] pc_inc, ras_top;
  logic              ras_empty, ras_ovf, ras_unf, unused_ras_full;
  logic [ISTK_W-1:0] istk_top;
  logic              istk_empty, istk_full, istk_ovf, istk_unf, unused_istk;

  assign unused_istk = istk_ovf | istk_unf;
  assign pc_inc      = pc + 1'b1;

  // one-hot event decode in priority order; stall kills everything
  assign int_acc  = ~stall & int_req & ~istk_full;
  assign ret_int  = ~stall & ~int_acc & ret & ~istk_empty;
  assign ret_sub  = ~stall & ~int_acc & ret & istk_empty;
  assign br_tkn   = ~stall & ~int_acc & ~ret & br & (|(cond_mask & flags_q));
  assign ras_push = br_tkn & save_addr;

  lifo_stack #(.WIDTH(ADDR_W), .DEPTH(RAS_DEPTH), .OVERWRITE(1'b1)) u_ras (
    .clk(clk), .rst_n(rst_n), .push(ras_push), .pop(ret_sub), .din(pc_inc),
    .top(ras_top), .empty(ras_empty), .full(unused_ras_full),
    .overflow(ras_ovf), .underflow(ras_unf)
  );

  lifo_stack #(.WIDTH(ISTK_W), .DEPTH(INT_DEPTH), .OVERWRITE(1'b0)) u_int_stk (
    .clk(clk), .rst_n(rst_n), .push(int_acc), .pop(ret_int), .din({pc, flags_q}),
    .top(istk_top), .empty(istk_empty), .full(istk_full),
    .overflow(istk_ovf), .underflow(istk_unf)
  );

  always_comb begin
    branch_taken = int_acc | ret_int | ret_sub | br_tkn;
    int_ack      = int_acc;
    branch_addr  = '0;
    if (int_acc)      branch_addr = int_vector;
    else if (ret_int) branch_addr = istk_top[ISTK_W-1:FLAG_W];
    else if (ret_sub) branch_addr = ras_empty ? pc_inc : ras_top;
    else if (br_tkn)  branch_addr = target;
  end

  always_comb begin
    flags_d     = flags_q;
    int_level_d = int_level_q;
    ras_err_d   = err_clr ? 2'b00 : ras_err_q;
    if (ret_int)                       flags_d = istk_top[FLAG_W-1:0];
    else if (~stall & ~int_acc & flag_wr) flags_d = flag_in;
    if (int_acc)      int_level_d = int_level_q + 1'b1;
    else if (ret_int) int_level_d = int_level_q - 1'b1;
    if (ras_ovf) ras_err_d[ERR_OVF] = 1'b1;
    if (ras_unf) ras_err_d[ERR_UNF] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= '0;
      int_level_q <= '0;
      ras_err_q   <= '0;
    end else begin
      flags_q     <= flags_d;
      int_level_q <= int_level_d;
      ras_err_q   <= ras_err_d;
    end
  end

  assign flags     = flags_q;
  assign int_level = int_level_q;
  assign ras_err   = ras_err_q;

endmodule

// File: tb/tb_ctrl_flow_unit.sv
// Directed plan steps plus random traffic, checked against a queue-based reference model.
module tb_ctrl_flow_unit;
  localparam int AW = 16;
  localparam int FW = 3;
  localparam int RD = 8;
  localparam int ID = 4;
  localparam int LW = $clog2(ID + 1);

  logic clk = 1'b0;
  logic rst_n, stall, br, save_addr, ret, flag_wr, int_req, err_clr;
  logic [AW-1:0] pc, target, int_vector;
  logic [FW-1:0] cond_mask, flag_in;
  logic branch_taken, int_ack;
  logic [AW-1:0] branch_addr;
  logic [LW-1:0] int_level;
  logic [FW-1:0] flags;
  logic [1:0] ras_err;

  ctrl_flow_unit #(.ADDR_W(AW), .FLAG_W(FW), .RAS_DEPTH(RD), .INT_DEPTH(ID)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .pc(pc), .target(target), .br(br),
    .cond_mask(cond_mask), .save_addr(save_addr), .ret(ret), .flag_wr(flag_wr),
    .flag_in(flag_in), .int_req(int_req), .int_vector(int_vector), .err_clr(err_clr),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .int_ack(int_ack),
    .int_level(int_level), .flags(flags), .ras_err(ras_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model: plain queues for both stacks
  logic [AW-1:0] m_ras[$];
  logic [AW-1:0] m_ipc[$];
  logic [FW-1:0] m_iflg[$];
  logic [FW-1:0] m_flags;
  logic [1:0]    m_err;
  logic          e_taken, e_ack;
  logic [AW-1:0] e_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ras.delete();
    m_ipc.delete();
    m_iflg.delete();
    m_flags = '0;
    m_err   = '0;
  endtask

  task automatic model_comb();
    logic [AW-1:0] inc;
    inc     = pc + 16'd1;
    e_taken = 1'b0;
    e_ack   = 1'b0;
    e_addr  = '0;
    if (!stall) begin
      if (int_req && m_ipc.size() < ID) begin
        e_ack = 1'b1; e_taken = 1'b1; e_addr = int_vector;
      end else if (ret && m_ipc.size() > 0) begin
        e_taken = 1'b1; e_addr = m_ipc[$];
      end else if (ret) begin
        e_taken = 1'b1; e_addr = (m_ras.size() > 0) ? m_ras[$] : inc;
      end else if (br && (cond_mask & m_flags) != '0) begin
        e_taken = 1'b1; e_addr = target;
      end
    end
  endtask

  task automatic model_edge();
    logic [1:0]    nerr;
    logic [AW-1:0] inc;
    logic          hit;
    nerr = '0;
    inc  = pc + 16'd1;
    hit  = (cond_mask & m_flags) != '0;
    if (!stall) begin
      if (int_req && m_ipc.size() < ID) begin
        m_ipc.push_back(pc);
        m_iflg.push_back(m_flags);
      end else if (ret && m_ipc.size() > 0) begin
        m_flags = m_iflg.pop_back();
        void'(m_ipc.pop_back());
      end else begin
        if (ret) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
          else nerr[1] = 1'b1;
        end else if (br && hit && save_addr) begin
          if (m_ras.size() == RD) begin
            void'(m_ras.pop_front());
            nerr[0] = 1'b1;
          end
          m_ras.push_back(inc);
        end
        if (flag_wr) m_flags = flag_in;
      end
    end
    if (err_clr) m_err = '0;
    m_err = m_err | nerr;
  endtask

  task automatic idle();
    stall = 0; br = 0; save_addr = 0; ret = 0; flag_wr = 0; int_req = 0; err_clr = 0;
    pc = '0; target = '0; int_vector = '0; cond_mask = '0; flag_in = '0;
  endtask

  // called at a falling edge with inputs already applied
  task automatic cycle(input string tag);
    model_comb();
    #1;
    chk({tag, ".taken"}, 32'(branch_taken), 32'(e_taken));
    if (e_taken) chk({tag, ".addr"}, 32'(branch_addr), 32'(e_addr));
    chk({tag, ".ack"},   32'(int_ack), 32'(e_ack));
    chk({tag, ".level"}, 32'(int_level), 32'(m_ipc.size()));
    chk({tag, ".flags"}, 32'(flags), 32'(m_flags));
    chk({tag, ".err"},   32'(ras_err), 32'(m_err));
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_call(input logic [AW-1:0] at, input logic [AW-1:0] tgt);
    idle(); br = 1; save_addr = 1; cond_mask = 3'b111; pc = at; target = tgt;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst.level", 32'(int_level), 32'd0);
    chk("rst.flags", 32'(flags), 32'd0);
    chk("rst.err",   32'(ras_err), 32'd0);
    chk("rst.taken", 32'(branch_taken), 32'd0);
    chk("rst.ack",   32'(int_ack), 32'd0);
    chk("rst.addr",  32'(branch_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: branch resolution on registered flags
    idle(); flag_wr = 1; flag_in = 3'b001; cycle("fw");
    idle(); br = 1; cond_mask = 3'b001; target = 16'h0040;
    #1; chk("br_hit.addr", 32'(branch_addr), 32'h0040);
    cycle("br_hit");
    cond_mask = 3'b110;
    #1; chk("br_miss.taken", 32'(branch_taken), 32'd0);
    cycle("br_miss");

    // 2: calls, RAS overflow/underflow, address wrap
    do_call(16'h0010, 16'h0200); cycle("call");
    idle(); ret = 1; pc = 16'h0200;
    #1; chk("ret.addr", 32'(branch_addr), 32'h0011);
    cycle("ret");
    for (int i = 0; i < 9; i++) begin
      do_call(16'(16'h0100 + i), 16'h0800); cycle("call9");
    end
    idle();
    chk("ovf.err", 32'(ras_err), 32'd1);
    for (int i = 0; i < 8; i++) begin
      idle(); ret = 1; pc = 16'h0900;
      #1; chk("unwind.addr", 32'(branch_addr), 32'(16'h0109 - i));
      cycle("unwind");
    end
    idle(); ret = 1; pc = 16'h0300;
    #1; chk("unf.addr", 32'(branch_addr), 32'h0301);
    cycle("unf");
    idle();
    chk("unf.err", 32'(ras_err), 32'd3);
    err_clr = 1; cycle("clr");
    idle();
    chk("clr.err", 32'(ras_err), 32'd0);
    do_call(16'hFFFF, 16'h0020); cycle("wrap_call");
    idle(); ret = 1; pc = 16'h0020;
    #1; chk("wrap.addr", 32'(branch_addr), 32'h0000);
    cycle("wrap_ret");

    // 3: single interrupt with flag save/restore
    idle(); flag_wr = 1; flag_in = 3'b100; cycle("fw100");
    idle(); int_req = 1; pc = 16'h0123; int_vector = 16'h0F00;
    #1; chk("int.ack", 32'(int_ack), 32'd1); chk("int.addr", 32'(branch_addr), 32'h0F00);
    cycle("int");
    idle();
    chk("int.level", 32'(int_level), 32'd1);
    flag_wr = 1; flag_in = 3'b010; pc = 16'h0F00; cycle("hnd_fw");
    idle(); ret = 1; pc = 16'h0F01;
    #1; chk("reti.addr", 32'(branch_addr), 32'h0123);
    cycle("reti");
    idle();
    chk("reti.flags", 32'(flags), 32'b100);
    chk("reti.level", 32'(int_level), 32'd0);

    // 4: nesting to the limit
    for (int i = 0; i < ID; i++) begin
      idle(); int_req = 1; pc = 16'(16'h0A00 + i); int_vector = 16'h0F00; cycle("nest");
    end
    idle(); int_req = 1; pc = 16'h0B00; int_vector = 16'h0F00;
    #1; chk("nest_full.ack", 32'(int_ack), 32'd0);
    cycle("nest_full");
    idle();
    chk("nest_full.level", 32'(int_level), 32'd4);
    for (int i = 0; i < ID; i++) begin
      idle(); ret = 1; pc = 16'h0F10;
      #1; chk("unnest.addr", 32'(branch_addr), 32'(16'h0A03 - i));
      cycle("unnest");
    end

    // 5: interrupt squashes a taken call with flag_wr
    idle(); flag_wr = 1; flag_in = 3'b001; cycle("fw001");
    do_call(16'h0500, 16'h0700); cond_mask = 3'b001;
    int_req = 1; int_vector = 16'h0F00; flag_wr = 1; flag_in = 3'b110;
    #1; chk("squash.ack", 32'(int_ack), 32'd1); chk("squash.addr", 32'(branch_addr), 32'h0F00);
    cycle("squash");
    idle();
    chk("squash.flags", 32'(flags), 32'b001);
    ret = 1; pc = 16'h0F00;
    #1; chk("resume.addr", 32'(branch_addr), 32'h0500);
    cycle("resume");
    do_call(16'h0500, 16'h0700); cycle("recall");
    idle(); ret = 1; pc = 16'h0700;
    #1; chk("recall_ret.addr", 32'(branch_addr), 32'h0501);
    cycle("recall_ret");
    idle(); ret = 1; pc = 16'h0777;
    #1; chk("empty_ret.addr", 32'(branch_addr), 32'h0778);
    cycle("empty_ret");

    // 6: stall freeze, then asynchronous reset inside a handler
    idle(); stall = 1; int_req = 1; br = 1; save_addr = 1; cond_mask = 3'b111;
    target = 16'h0040; pc = 16'h0600; int_vector = 16'h0F00; err_clr = 1;
    #1; chk("stall.taken", 32'(branch_taken), 32'd0); chk("stall.ack", 32'(int_ack), 32'd0);
    cycle("stall");
    idle();
    chk("stall.level", 32'(int_level), 32'd0);
    int_req = 1; pc = 16'h0610; int_vector = 16'h0F00; cycle("int2");
    idle(); flag_wr = 1; flag_in = 3'b110; cycle("hnd2");
    idle();
    #3 rst_n = 1'b0;
    #1;
    chk("arst.level", 32'(int_level), 32'd0);
    chk("arst.flags", 32'(flags), 32'd0);
    chk("arst.err",   32'(ras_err), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      stall      = ($urandom_range(0, 9) == 0);
      int_req    = ($urandom_range(0, 7) == 0);
      ret        = ($urandom_range(0, 3) == 0);
      br         = ($urandom_range(0, 1) == 1);
      save_addr  = ($urandom_range(0, 1) == 1);
      flag_wr    = ($urandom_range(0, 2) == 0);
      err_clr    = ($urandom_range(0, 15) == 0);
      cond_mask  = FW'($urandom);
      flag_in    = FW'($urandom);
      pc         = ($urandom_range(0, 15) == 0) ? 16'hFFFF : AW'($urandom);
      target     = AW'($urandom);
      int_vector = AW'($urandom);
      cycle("rnd");
      if (n == 300) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rnd_rst.level", 32'(int_level), 32'd0);
        chk("rnd_rst.flags", 32'(flags), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
